// File: rtl/lpf_ctrl_pkg.sv
// lpf_ctrl_pkg: shared state enum, frame-size helpers and cutoff clamp for the LPF cutoff controller
package lpf_ctrl_pkg;
  typedef enum logic [1:0] {UNLOCKED, IDLE, RAMP} state_t;
  function automatic int unsigned n_of(input int unsigned lg);
    return 32'd1 << lg;
  endfunction
  function automatic int unsigned nyq_of(input int unsigned lg);
    return n_of(lg) >> 1;
  endfunction
  function automatic int unsigned clamp_cutoff(input int unsigned c, input int unsigned nyq);
    return (c > nyq) ? nyq : c;
  endfunction
endpackage

// File: rtl/lpf_cutoff_ctrl_if.sv
// lpf_cutoff_ctrl_if: cutoff-change request handshake (valid/ready + target cutoff + ramp step); master = host, slave = controller
interface lpf_cutoff_ctrl_if #(parameter int LGWIDTH = 9, parameter int LGSTEP = 6);
  logic               req_valid;
  logic               req_ready;
  logic [LGWIDTH:0]   req_cutoff;
  logic [LGSTEP-1:0]  req_step;
  modport master(output req_valid, req_cutoff, req_step, input req_ready);
  modport slave(input req_valid, req_cutoff, req_step, output req_ready);
endinterface

// File: rtl/lpf_frame_counter.sv
// lpf_frame_counter: FFT bin counter, lock flag, frame-end strobe and optional sync watchdog (LPF_CTRL_WDOG_EN)
// Ports: i_clk, i_reset_n (async, active low), i_ce/i_sync (LPF stream strobes), i_err_clr (clears o_sync_err),
//        o_locked (alignment acquired), o_lock_evt (first aligned sync this cycle), o_fe (last bin of a frame), o_sync_err (sticky)
module lpf_frame_counter #(
  parameter int LGWIDTH = 9
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_ce,
  input  logic i_sync,
  input  logic i_err_clr,
  output logic o_locked,
  output logic o_lock_evt,
  output logic o_fe,
  output logic o_sync_err
);
  logic [LGWIDTH-1:0] cnt_q, cnt_d;
  logic locked_q, sof;
  assign sof = i_ce & i_sync;
  // sync means the current sample is bin 0, so the next one is bin 1
  assign cnt_d = sof ? LGWIDTH'(1) : (i_ce ? cnt_q + 1'b1 : cnt_q);
  assign o_locked = locked_q;
  assign o_lock_evt = sof & ~locked_q;
  // a sync landing on bin N-1 truncates the frame, so it never produces a frame end
  assign o_fe = locked_q & i_ce & ~i_sync & (&cnt_q);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      cnt_q <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      locked_q <= locked_q | sof;
    end
`ifdef LPF_CTRL_WDOG_EN
  logic err_q, err_set;
  // misaligned sync, or a bin 0 arriving after the wrap without its sync
  assign err_set = locked_q & i_ce & (i_sync ? (cnt_q != '0) : (cnt_q == '0));
  assign o_sync_err = err_q;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) err_q <= 1'b0;
    else err_q <= err_set | (err_q & ~i_err_clr);
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_sync_err = 1'b0;
`endif
endmodule

// File: rtl/lpf_cutoff_ctrl.sv
// lpf_cutoff_ctrl: frame-aligned, step-ramped cutoff sequencer for the FFT-domain LPF (watchdog via LPF_CTRL_WDOG_EN)
// Ports: i_clk, i_reset_n (async, active low), i_ce/i_sync (shared with LPF), req (request handshake, slave),
//        o_cutoff (registered LPF cutoff), o_busy (ramping), o_done (target reached pulse), o_locked,
//        i_err_clr/o_sync_err (watchdog clear / sticky error)
module lpf_cutoff_ctrl
  import lpf_ctrl_pkg::*;
#(
  parameter int LGWIDTH     = 9,
  parameter int LGSTEP      = 6,
  parameter int INIT_CUTOFF = 64
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic               i_sync,
  lpf_cutoff_ctrl_if.slave   req,
  output logic [LGWIDTH:0]   o_cutoff,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_locked,
  input  logic               i_err_clr,
  output logic               o_sync_err
);
  localparam int CW = LGWIDTH + 1;
  localparam int unsigned NYQ = nyq_of(LGWIDTH);
  typedef logic [CW-1:0] cut_t;
  localparam cut_t INIT = cut_t'(INIT_CUTOFF);
  state_t state_q, state_d;
  cut_t cut_q, cut_d, tgt_q, tgt_d, req_tgt, diff, step_w;
  logic [LGSTEP-1:0] step_q, step_d;
  logic done_q, done_d, acc, lock_evt, fe, up;
  lpf_frame_counter #(.LGWIDTH(LGWIDTH)) u_cnt (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_sync(i_sync), .i_err_clr(i_err_clr),
    .o_locked(o_locked), .o_lock_evt(lock_evt), .o_fe(fe), .o_sync_err(o_sync_err)
  );
  assign req.req_ready = state_q != RAMP;
  assign acc = req.req_valid & req.req_ready;
  assign req_tgt = cut_t'(clamp_cutoff(32'(req.req_cutoff), NYQ));
  assign up = tgt_q > cut_q;
  assign diff = up ? tgt_q - cut_q : cut_q - tgt_q;
  assign step_w = cut_t'(step_q);
  assign o_cutoff = cut_q;
  assign o_busy = state_q == RAMP;
  assign o_done = done_q;
  always_comb begin
    state_d = state_q;
    cut_d = cut_q;
    tgt_d = acc ? req_tgt : tgt_q;
    step_d = acc ? req.req_step : step_q;
    done_d = acc & (req_tgt == cut_q);
    case (state_q)
      UNLOCKED: state_d = lock_evt ? ((tgt_d != cut_q) ? RAMP : IDLE) : UNLOCKED;
      IDLE:     state_d = (acc && req_tgt != cut_q) ? RAMP : IDLE;
      RAMP:
        if (fe) begin
          if (step_q == '0 || diff <= step_w) begin
            cut_d = tgt_q;
            done_d = 1'b1;
            state_d = IDLE;
          end else begin
            cut_d = up ? cut_q + step_w : cut_q - step_w;
          end
        end
      default:  state_d = UNLOCKED;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= UNLOCKED;
      cut_q <= INIT;
      tgt_q <= INIT;
      step_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cut_q <= cut_d;
      tgt_q <= tgt_d;
      step_q <= step_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_lpf_cutoff_ctrl.sv
// tb_lpf_cutoff_ctrl: directed table-driven checks of lock, ramping, clamp, freeze, realign and reset
module tb_lpf_cutoff_ctrl;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_ce = 1'b1, i_sync = 1'b0, i_err_clr = 1'b0;
  logic [9:0] o_cutoff;
  logic o_busy, o_done, o_locked, o_sync_err;
  logic [8:0] bin = '0;
  logic sync_en = 1'b0;
  int tests = 0, fails = 0;
`ifdef LPF_CTRL_WDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif
  typedef struct {
    logic [9:0]       cutoff;
    logic [5:0]       step;
    int               nexp;
    logic [3:0][9:0]  exp;
  } vec_t;
  vec_t vt[5];
  logic [3:0][9:0] dn;
  lpf_cutoff_ctrl_if #(.LGWIDTH(9), .LGSTEP(6)) bus ();
  lpf_cutoff_ctrl #(.LGWIDTH(9), .LGSTEP(6), .INIT_CUTOFF(64)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_sync(i_sync), .req(bus),
    .o_cutoff(o_cutoff), .o_busy(o_busy), .o_done(o_done), .o_locked(o_locked),
    .i_err_clr(i_err_clr), .o_sync_err(o_sync_err)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (i_ce) bin = bin + 9'd1;
    i_sync = sync_en && (bin == 9'd0);
  endtask
  // advance until just after the edge that consumes bin 511 (the frame-end edge)
  task automatic to_fe();
    int g = 0;
    while (bin != 9'd511 && g < 2000) begin
      tick();
      g++;
    end
    tick();
  endtask
  task automatic request(input logic [9:0] c, input logic [5:0] s);
    bus.req_valid = 1'b1;
    bus.req_cutoff = c;
    bus.req_step = s;
    chk("req_ready_before", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
  endtask
  initial begin
    vt[0] = '{10'd100, 6'd16, 3, {10'd0, 10'd100, 10'd96, 10'd80}};
    vt[1] = '{10'd400, 6'd0, 1, {10'd0, 10'd0, 10'd0, 10'd256}};
    vt[2] = '{10'd256, 6'd0, 0, {10'd0, 10'd0, 10'd0, 10'd0}};
    vt[3] = '{10'd200, 6'd40, 2, {10'd0, 10'd0, 10'd200, 10'd216}};
    vt[4] = '{10'd1023, 6'd63, 1, {10'd0, 10'd0, 10'd0, 10'd256}};
    bus.req_valid = 1'b0;
    bus.req_cutoff = '0;
    bus.req_step = '0;
    #12;
    chk("rst_cutoff", 32'(o_cutoff), 64);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_sync_err", 32'(o_sync_err), 0);
    i_reset_n = 1'b1;
    repeat (9) tick();
    chk("prelock_locked", 32'(o_locked), 0);
    bin = '0;
    sync_en = 1'b1;
    i_sync = 1'b1;
    tick();
    chk("lock_locked", 32'(o_locked), 1);
    chk("lock_cutoff", 32'(o_cutoff), 64);
    chk("lock_busy", 32'(o_busy), 0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      request(vt[i].cutoff, vt[i].step);
      if (vt[i].nexp == 0) begin
        chk("eq_done", 32'(o_done), 1);
        chk("eq_busy", 32'(o_busy), 0);
        chk("eq_ready", 32'(bus.req_ready), 1);
        tick();
        chk("eq_done_end", 32'(o_done), 0);
      end else begin
        chk("ramp_busy", 32'(o_busy), 1);
        chk("ramp_ready", 32'(bus.req_ready), 0);
        for (int k = 0; k < vt[i].nexp; k++) begin
          to_fe();
          chk("ramp_cutoff", 32'(o_cutoff), 32'(vt[i].exp[k]));
          chk("ramp_done", 32'(o_done), 32'(k == vt[i].nexp - 1));
          chk("ramp_busy_fe", 32'(o_busy), 32'(k != vt[i].nexp - 1));
        end
        tick();
        chk("ramp_done_end", 32'(o_done), 0);
        chk("ramp_ready_end", 32'(bus.req_ready), 1);
      end
    end
    #3 i_reset_n = 1'b0;
    #1;
    chk("rst2_cutoff", 32'(o_cutoff), 64);
    chk("rst2_locked", 32'(o_locked), 0);
    sync_en = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
    request(10'd32, 6'd8);
    repeat (5) tick();
    chk("unl_cutoff", 32'(o_cutoff), 64);
    chk("unl_busy", 32'(o_busy), 0);
    chk("unl_ready", 32'(bus.req_ready), 1);
    bin = '0;
    sync_en = 1'b1;
    i_sync = 1'b1;
    tick();
    chk("unl_lock_busy", 32'(o_busy), 1);
    chk("unl_lock_ready", 32'(bus.req_ready), 0);
    dn = {10'd32, 10'd40, 10'd48, 10'd56};
    for (int k = 0; k < 4; k++) begin
      to_fe();
      chk("unl_ramp_cutoff", 32'(o_cutoff), 32'(dn[k]));
      chk("unl_ramp_done", 32'(o_done), 32'(k == 3));
    end
    tick();
    request(10'd100, 6'd16);
    while (bin != 9'd200) tick();
    bin = '0;
    i_sync = 1'b1;
    tick();
    chk("inj_sync_err", 32'(o_sync_err), 32'(WD));
    chk("inj_cutoff", 32'(o_cutoff), 32);
    to_fe();
    chk("realign_cutoff", 32'(o_cutoff), 48);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("err_clr", 32'(o_sync_err), 0);
    to_fe();
    chk("ramp2_cutoff", 32'(o_cutoff), 64);
    while (bin != 9'd511) tick();
    i_ce = 1'b0;
    repeat (5) tick();
    chk("freeze_cutoff", 32'(o_cutoff), 64);
    chk("freeze_busy", 32'(o_busy), 1);
    i_ce = 1'b1;
    tick();
    chk("unfreeze_cutoff", 32'(o_cutoff), 80);
    tick();
    #2 i_reset_n = 1'b0;
    #1;
    chk("midrst_cutoff", 32'(o_cutoff), 64);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_locked", 32'(o_locked), 0);
    chk("midrst_ready", 32'(bus.req_ready), 1);
    tick();
    i_reset_n = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
